// File: rtl/barrel_motion_if.sv
// -----------------------------------------------------------------------------
// barrel_motion_if
// Bundles the control inputs and sprite outputs of one barrel sequencer.
//   frame_tick    : one pulse per video frame (master -> slave)
//   spawn         : start a barrel                  (master -> slave)
//   kill          : abort the current barrel        (master -> slave)
//   pause         : freeze motion, only when BARREL_PAUSE_EN is defined
//   posx  [9:0]   : sprite left column              (slave -> master)
//   posy  [8:0]   : sprite top row                  (slave -> master)
//   animate_state : sprite frame select             (slave -> master)
//   active        : barrel in flight                (slave -> master)
//   done          : one-cycle pulse on bottom exit  (slave -> master)
// Optional feature macro: BARREL_PAUSE_EN
// -----------------------------------------------------------------------------
interface barrel_motion_if;
   logic       frame_tick;
   logic       spawn;
   logic       kill;
`ifdef BARREL_PAUSE_EN
   logic       pause;
`endif
   logic [9:0] posx;
   logic [8:0] posy;
   logic [2:0] animate_state;
   logic       active;
   logic       done;

   modport master (
`ifdef BARREL_PAUSE_EN
      output pause,
`endif
      output frame_tick, spawn, kill,
      input  posx, posy, animate_state, active, done
   );

   modport slave (
`ifdef BARREL_PAUSE_EN
      input  pause,
`endif
      input  frame_tick, spawn, kill,
      output posx, posy, animate_state, active, done
   );
endinterface

// File: rtl/barrel_motion.sv
// -----------------------------------------------------------------------------
// barrel_motion
// Moves one barrel down a zig-zag of platforms, one step per accepted frame
// tick: roll to the platform edge, fall to the next platform, reverse, repeat.
// Drives the sprite position and frame select of the barrel colour stage.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : barrel_motion_if.slave (frame_tick/spawn/kill[/pause] in,
//           posx/posy/animate_state/active/done out)
// Optional feature macro: BARREL_PAUSE_EN (adds the pause input; while high,
//   frame ticks are ignored but kill and spawn are still honoured).
// -----------------------------------------------------------------------------
module barrel_motion #(
   parameter int X_MIN      = 8,
   parameter int X_MAX      = 600,
   parameter int Y_START    = 40,
   parameter int LEVEL_STEP = 80,
   parameter int NUM_LEVELS = 5,
   parameter int ROLL_SPEED = 2,
   parameter int FALL_SPEED = 4,
   parameter int ANIM_DIV   = 4,
   parameter int FALL_XOFF  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   barrel_motion_if.slave    bus
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_ROLL = 2'b01;
   localparam logic [1:0] ST_FALL = 2'b10;

   localparam int AW = (ANIM_DIV   > 1) ? $clog2(ANIM_DIV)   : 1;
   localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

   // x math runs one bit wider than posx and y math one bit wider than posy,
   // so the saturation compares can never see a wrapped value.
   localparam logic [10:0]   LP_X_MIN      = 11'(X_MIN);
   localparam logic [10:0]   LP_X_MAX      = 11'(X_MAX);
   localparam logic [10:0]   LP_ROLL       = 11'(ROLL_SPEED);
   localparam logic [10:0]   LP_XOFF       = 11'(FALL_XOFF);
   localparam logic [9:0]    LP_XOFF10     = 10'(FALL_XOFF);
   localparam logic [9:0]    LP_FALL       = 10'(FALL_SPEED);
   localparam logic [9:0]    LP_POSX_RST   = 10'(X_MIN);
   localparam logic [8:0]    LP_Y_START    = 9'(Y_START);
   localparam logic [8:0]    LP_STEP       = 9'(LEVEL_STEP);
   localparam logic [AW-1:0] LP_ANIM_LAST  = AW'(ANIM_DIV - 1);
   localparam logic [LW-1:0] LP_LAST_LEVEL = LW'(NUM_LEVELS - 1);

   logic [1:0]    r_state;
   logic [9:0]    r_posx;
   logic [8:0]    r_posy;
   logic [2:0]    r_anim;
   logic          r_done;
   logic [LW-1:0] r_level;
   logic          r_dir;          // 0 = moving right, 1 = moving left
   logic [AW-1:0] r_anim_cnt;
   logic [8:0]    r_fall_target;

   logic          w_tick;
   logic [10:0]   w_x_ext;
   logic [10:0]   w_x_right;
   logic          w_right_edge;
   logic          w_left_edge;
   logic          w_edge;
   logic [10:0]   w_x_roll;
   logic [9:0]    w_y_next;
   logic          w_land;
   logic          w_anim_wrap;
   logic [AW-1:0] w_anim_cnt_nxt;
   logic [1:0]    w_roll_frame;

`ifdef BARREL_PAUSE_EN
   assign w_tick = bus.frame_tick & ~bus.pause;
`else
   assign w_tick = bus.frame_tick;
`endif

   // Roll step with saturation at the platform ends; the saturating step is
   // the edge event.
   assign w_x_ext      = {1'b0, r_posx};
   assign w_x_right    = w_x_ext + LP_ROLL;
   assign w_right_edge = (w_x_right >= LP_X_MAX);
   assign w_left_edge  = (w_x_ext <= (LP_X_MIN + LP_ROLL));
   assign w_edge       = r_dir ? w_left_edge : w_right_edge;
   assign w_x_roll     = r_dir ? (w_left_edge  ? LP_X_MIN : (w_x_ext - LP_ROLL))
                               : (w_right_edge ? LP_X_MAX : w_x_right);

   // Fall step; landing is the tick that reaches (or would pass) the target.
   assign w_y_next = {1'b0, r_posy} + LP_FALL;
   assign w_land   = (w_y_next >= {1'b0, r_fall_target});

   assign w_anim_wrap    = (r_anim_cnt == LP_ANIM_LAST);
   assign w_anim_cnt_nxt = w_anim_wrap ? '0 : (r_anim_cnt + AW'(1));
   // Roll frames cycle forward when moving right and backward when moving left.
   assign w_roll_frame   = r_dir ? (r_anim[1:0] - 2'd1) : (r_anim[1:0] + 2'd1);

   // NOTE: every register here is assigned with <= so all updates in one clock
   // see the pre-edge values; mixing in = would make results order-dependent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_posx        <= LP_POSX_RST;
         r_posy        <= LP_Y_START;
         r_anim        <= 3'b000;
         r_done        <= 1'b0;
         r_level       <= '0;
         r_dir         <= 1'b0;
         r_anim_cnt    <= '0;
         r_fall_target <= LP_Y_START;
      end else begin
         r_done <= 1'b0;
         if (bus.kill) begin
            r_state <= ST_IDLE;
            r_posx  <= LP_POSX_RST;
            r_posy  <= LP_Y_START;
            r_anim  <= 3'b000;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // A frame tick in the spawn cycle is swallowed: no motion yet.
                  if (bus.spawn) begin
                     r_state    <= ST_ROLL;
                     r_posx     <= LP_POSX_RST;
                     r_posy     <= LP_Y_START;
                     r_level    <= '0;
                     r_dir      <= 1'b0;
                     r_anim     <= 3'b000;
                     r_anim_cnt <= '0;
                  end
               end
               ST_ROLL: begin
                  if (w_tick) begin
                     if (w_edge) begin
                        if (r_level == LP_LAST_LEVEL) begin
                           r_state <= ST_IDLE;
                           r_done  <= 1'b1;
                           r_posx  <= LP_POSX_RST;
                           r_posy  <= LP_Y_START;
                           r_anim  <= 3'b000;
                        end else begin
                           // Shift left so the wider fall sprite stays centred.
                           r_state       <= ST_FALL;
                           r_posx        <= 10'(w_x_roll - LP_XOFF);
                           r_anim        <= 3'b100;
                           r_anim_cnt    <= '0;
                           r_fall_target <= r_posy + LP_STEP;
                        end
                     end else begin
                        r_posx     <= 10'(w_x_roll);
                        r_anim_cnt <= w_anim_cnt_nxt;
                        if (w_anim_wrap) begin
                           r_anim <= {1'b0, w_roll_frame};
                        end
                     end
                  end
               end
               ST_FALL: begin
                  if (w_tick) begin
                     if (w_land) begin
                        r_state    <= ST_ROLL;
                        r_posy     <= r_fall_target;
                        r_posx     <= r_posx + LP_XOFF10;
                        r_level    <= r_level + LW'(1);
                        r_dir      <= ~r_dir;
                        r_anim     <= 3'b000;
                        r_anim_cnt <= '0;
                     end else begin
                        r_posy     <= 9'(w_y_next);
                        r_anim_cnt <= w_anim_cnt_nxt;
                        if (w_anim_wrap) begin
                           r_anim <= {2'b10, ~r_anim[0]};
                        end
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.posx          = r_posx;
   assign bus.posy          = r_posy;
   assign bus.animate_state = r_anim;
   assign bus.active        = (r_state != ST_IDLE);
   assign bus.done          = r_done;

endmodule

// File: tb/tb_barrel_motion.sv
// -----------------------------------------------------------------------------
// tb_barrel_motion
// Self-checking bench for barrel_motion: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run compared against a
// closed-form trajectory model (position/frame as a function of tick count).
// Optional feature macro: BARREL_PAUSE_EN (enables the pause sequence).
// -----------------------------------------------------------------------------
module tb_barrel_motion;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   barrel_motion_if bus ();

   barrel_motion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Trajectory constants for the default parameter set.
   localparam int M_ROLL  = (600 - 8) / 2;          // ticks per platform roll
   localparam int M_FALL  = 80 / 4;                 // ticks per fall
   localparam int M_SEG   = M_ROLL + M_FALL;        // roll + fall per level
   localparam int M_TOTAL = 5 * M_ROLL + 4 * M_FALL;

   typedef logic [23:0] obs_t;   // {posx, posy, animate_state, active, done}

   typedef struct {
      int         reps;
      logic       spawn;
      logic       kill;
      logic       tick;
      logic [9:0] x;
      logic [8:0] y;
      logic [2:0] a;
      logic       act;
      logic       dn;
      string      name;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic obs_t observe();
      return {bus.posx, bus.posy, bus.animate_state, bus.active, bus.done};
   endfunction

   function automatic obs_t idle_out(logic dn);
      return {10'd8, 9'd40, 3'd0, 1'b0, dn};
   endfunction

   // Expected outputs after t accepted ticks since spawn (t < M_TOTAL).
   function automatic obs_t flight_out(int t);
      int lvl, r, f, x, y, a;
      lvl = t / M_SEG;
      r   = t % M_SEG;
      y   = 40 + 80 * lvl;
      if (r < M_ROLL) begin
         if (lvl % 2 == 0) begin
            x = 8 + 2 * r;
            a = (r / 4) % 4;
         end else begin
            x = 600 - 2 * r;
            a = (4 - (r / 4) % 4) % 4;
         end
      end else begin
         f = r - M_ROLL;
         x = (lvl % 2 == 0) ? 600 - 5 : 8 - 5;
         y = y + 4 * f;
         a = 4 + (f / 4) % 2;
      end
      return {10'(x), 9'(y), 3'(a), 1'b1, 1'b0};
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t got;
      got = observe();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d anim=%0d act=%0b done=%0b, want x=%0d y=%0d anim=%0d act=%0b done=%0b",
                  name, got[23:14], got[13:5], got[4:2], got[1], got[0],
                  exp[23:14], exp[13:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   task automatic drive(input logic sp, input logic kl, input logic tk);
      bus.spawn      = sp;
      bus.kill       = kl;
      bus.frame_tick = tk;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int reps, input logic sp, input logic kl, input logic tk,
                      input int x, input int y, input int a, input logic act,
                      input logic dn, input string name);
      vec_t v;
      v.reps = reps; v.spawn = sp; v.kill = kl; v.tick = tk;
      v.x = 10'(x); v.y = 9'(y); v.a = 3'(a); v.act = act; v.dn = dn;
      v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   m_t;
      logic m_act;
      obs_t exp;
      logic sp, kl, tk;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
`ifdef BARREL_PAUSE_EN
      bus.pause = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // ---------------- directed vector table ----------------
      add(0,    0, 0, 0,   8,  40, 0, 0, 0, "reset_state");
      add(1,    1, 0, 0,   8,  40, 0, 1, 0, "spawn");
      add(4,    0, 0, 1,  16,  40, 1, 1, 0, "roll_4_ticks");
      add(292,  0, 0, 1, 595,  40, 4, 1, 0, "right_edge_to_fall");
      add(4,    0, 0, 1, 595,  56, 5, 1, 0, "fall_4_ticks");
      add(16,   0, 0, 1, 600, 120, 0, 1, 0, "land_level1");
      add(4,    0, 0, 1, 592, 120, 3, 1, 0, "roll_left_anim_dec");
      add(1,    1, 0, 1, 590, 120, 3, 1, 0, "spawn_active_tick");
      add(1,    1, 0, 0, 590, 120, 3, 1, 0, "spawn_active_ignored");
      add(1,    0, 1, 0,   8,  40, 0, 0, 0, "kill_roll");
      add(1,    1, 0, 1,   8,  40, 0, 1, 0, "spawn_and_tick_idle");
      add(10,   0, 0, 1,  28,  40, 2, 1, 0, "roll_10_ticks");
      add(290,  0, 0, 1, 595,  56, 5, 1, 0, "mid_fall");
      add(1,    1, 1, 1,   8,  40, 0, 0, 0, "kill_spawn_mid_fall");
      add(1,    1, 0, 0,   8,  40, 0, 1, 0, "respawn");
      add(612,  0, 0, 1,   3, 120, 4, 1, 0, "left_edge_to_fall");
      add(947,  0, 0, 1, 598, 360, 1, 1, 0, "last_level_before_exit");
      add(1,    0, 0, 1,   8,  40, 0, 0, 1, "done_pulse");
      add(1,    0, 0, 1,   8,  40, 0, 0, 0, "done_cleared_idle_tick");

      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].reps; k++) begin
            drive(vecs[i].spawn, vecs[i].kill, vecs[i].tick);
            cycle();
         end
         drive(1'b0, 1'b0, 1'b0);
         check(vecs[i].name, {vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].act, vecs[i].dn});
      end

      // ---------------- asynchronous reset mid-flight ----------------
      drive(1'b1, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b1);
      repeat (30) cycle();
      drive(1'b0, 1'b0, 1'b0);
      check("pre_async_reset", flight_out(30));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", idle_out(1'b0));
      #2;
      rst_n = 1'b1;
      cycle();
      check("after_async_reset", idle_out(1'b0));

`ifdef BARREL_PAUSE_EN
      // ---------------- pause ----------------
      drive(1'b1, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b1);
      repeat (20) cycle();
      check("pre_pause", flight_out(20));
      bus.pause = 1'b1;
      repeat (10) cycle();
      check("paused_hold", flight_out(20));
      bus.pause = 1'b0;
      repeat (4) cycle();
      check("pause_release", flight_out(24));
      bus.pause = 1'b1;
      drive(1'b0, 1'b1, 1'b1);
      cycle();
      check("kill_while_paused", idle_out(1'b0));
      bus.pause = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
`endif

      // ---------------- randomized run vs trajectory model ----------------
      m_act = 1'b0;
      m_t   = 0;
      for (int n = 0; n < 6000; n++) begin
         sp = ($urandom_range(0, 39) == 0);
         kl = ($urandom_range(0, 2999) == 0);
         tk = ($urandom_range(0, 3) != 0);
         drive(sp, kl, tk);
         cycle();
         if (kl) begin
            m_act = 1'b0;
            exp   = idle_out(1'b0);
         end else if (!m_act && sp) begin
            m_act = 1'b1;
            m_t   = 0;
            exp   = flight_out(0);
         end else if (m_act && tk) begin
            m_t++;
            if (m_t == M_TOTAL) begin
               m_act = 1'b0;
               exp   = idle_out(1'b1);
            end else begin
               exp = flight_out(m_t);
            end
         end else begin
            exp = m_act ? flight_out(m_t) : idle_out(1'b0);
         end
         check("random", exp);
      end
      drive(1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/barrel_motion.md
# barrel_motion

Per-barrel motion and animation sequencer sitting directly upstream of the barrel sprite colour stage. On a spawn request it moves one barrel down a fixed zig-zag of platforms: roll to the edge, fall to the next platform, reverse, repeat. Once per video frame it advances the barrel's top-left pixel position (`posx`/`posy`) and its 3-bit sprite frame select (`animate_state`). These outputs drive the colour stage directly.

## Interface
- `X_MIN`, 8: leftmost roll `posx`.
- `X_MAX`, 600: rightmost roll `posx`.
- `Y_START`, 40: `posy` of top platform.
- `LEVEL_STEP`, 80: vertical pixels between platforms.
- `NUM_LEVELS`, 5: platform count.
- `ROLL_SPEED`, 2: px per frame tick while rolling.
- `FALL_SPEED`, 4: px per frame tick while falling.
- `ANIM_DIV`, 4: frame ticks per sprite frame.
- `FALL_XOFF`, 5: left shift applied while falling, to centre the 42-px fall sprite over the 32-px roll sprite.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `spawn`  in  1  start a barrel.
- `kill`  in  1  abort the current barrel.
- `pause`  in  1  freeze motion; present only with `BARREL_PAUSE_EN`.
- `posx`  out  10  sprite left column.
- `posy`  out  9  sprite top row.
- `animate_state`  out  3  sprite frame select.
  - 000–011: roll frames 1–4.
  - 100, 101: fall frames 1–2.
- `active`  out  1  barrel in flight.
- `done`  out  1  one-cycle pulse when the barrel exits the bottom platform.

## Operation
- States:
  - IDLE: `active` = 0.
  - ROLL: `active` = 1.
  - FALL: `active` = 1.
- Internal registers:
  - `level`: 0..NUM_LEVELS-1.
  - `dir`: 0 = right, 1 = left.
  - `anim_cnt`: 0..ANIM_DIV-1.
  - `fall_target`: 9 bits.
- IDLE → ROLL on `spawn`:
  - `posx` = X_MIN, `posy` = Y_START.
  - `level` = 0, `dir` = right, `animate_state` = 000, `anim_cnt` = 0.
- ROLL, on each accepted tick:
  - `posx` moves ±ROLL_SPEED and saturates at X_MAX (right) or X_MIN (left).
  - `anim_cnt` increments. On wrap, `animate_state` changes modulo 4: +1 when moving right, −1 when moving left.
- Edge reached in ROLL (the saturating tick), when `level` < NUM_LEVELS-1:
  - Go to FALL.
  - `posx` −= FALL_XOFF.
  - `animate_state` = 100, `anim_cnt` = 0.
  - `fall_target` = `posy` + LEVEL_STEP.
- Edge reached in ROLL on the last level:
  - Go to IDLE and pulse `done`.
  - `posx` = X_MIN, `posy` = Y_START, `animate_state` = 000.
- FALL, on each accepted tick:
  - `posy` += FALL_SPEED, saturating at `fall_target`.
  - On `anim_cnt` wrap, `animate_state` toggles between 100 and 101.
- Landing (`posy` reaches `fall_target`):
  - Go to ROLL.
  - `posx` += FALL_XOFF.
  - `level` += 1, `dir` inverts.
  - `animate_state` = 000, `anim_cnt` = 0.
- Accepted tick: `frame_tick` & ~`pause`. Without the macro, `pause` is treated as 0.
- Priority, highest first:
  1. `kill`: from any state, go to IDLE, reload `posx`/`posy`/`animate_state` to reset values, no `done` pulse.
  2. `spawn`: only when in IDLE.
  3. Accepted tick.
- `spawn` while `active` is ignored.
- `spawn` and `frame_tick` in the same IDLE cycle: spawn only; no motion that cycle.
- Width rules:
  - Saturation compares use 11-bit (x) and 10-bit (y) intermediates, so no wrap is possible.
  - Parameters must satisfy X_MIN ≥ FALL_XOFF and X_MAX + 42 − FALL_XOFF ≤ 640.

## Timing
- All outputs are registered and update on the rising `clk` edge of the triggering cycle. Latency is 1 cycle from `spawn`, `kill` or `frame_tick`.
- Reset values: `posx` = X_MIN, `posy` = Y_START, `animate_state` = 000, `active` = 0, `done` = 0, state = IDLE.
- Reset asserted mid-flight returns all outputs to reset values immediately (asynchronous).
- `done` is high for exactly one `clk` cycle, in the same cycle `active` falls.
- At most one position step per accepted tick. A multi-cycle `frame_tick` counts once per high cycle.

## Configuration
- `BARREL_PAUSE_EN` defined:
  - The `pause` port exists.
  - While `pause` = 1, frame ticks are ignored: position, `anim_cnt` and `animate_state` hold.
  - `kill` and `spawn` are still honoured.
- `BARREL_PAUSE_EN` undefined: the port is absent and every `frame_tick` is accepted.

## Test plan
- Reset, then `spawn` → next cycle `active` = 1, `posx` = 8, `posy` = 40, `animate_state` = 000. After 4 ticks → `animate_state` = 001, `posx` = 16.
- 296 ticks after spawn → `posx` = 600 then 595, FALL, `animate_state` = 100. 20 further ticks → `posy` = 120, `posx` = 600, ROLL, `level` = 1. Next 4 ticks → `animate_state` = 011 (decrementing, moving left).
- Full run with default parameters → `done` pulses exactly 1560 ticks after spawn. `active` = 0, `posx` = 8, `posy` = 40 afterward.
- `kill` mid-FALL, with `spawn` high in the same cycle → IDLE, no `done`. `spawn` one cycle later → restart at (8, 40).
- `spawn` while `active` → ignored; `level` and position unchanged.
- With `BARREL_PAUSE_EN`, `pause` = 1 for 10 ticks mid-roll → `posx` and `animate_state` unchanged. Release `pause` → motion resumes from the held values.
